// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the two-requester register-file arbiter:
//   - default geometry of the register file (entry count, data width)
//   - FSM state encoding (plain localparam constants)
//   - requester identifier type used by the round-robin pointer
// ---------------------------------------------------------------------------
package regfile_pkg;

  // Default geometry. Addresses are 5 bits wide, so at most 32 entries.
  localparam int NUM_REG_DEFAULT = 32;
  localparam int WIDTH_DEFAULT   = 16;
  localparam int ADDR_W          = 5;

  // FSM state encoding.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Requester identifier; also the encoding of the round-robin pointer.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  // The requester that did not win; the pointer moves there after a grant.
  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/regfile_arbiter_addr_decoder.sv
// ---------------------------------------------------------------------------
// addr_decoder_5to32
// Combinational 5-bit to 32-bit one-hot decoder. The output vector is
// numbered 32..1 so that address i raises bit i+1, which lines up directly
// with the register entry numbering (entries 1..32).
//
// Ports
//   addr_i    [4:0]   zero-based address
//   onehot_o  [32:1]  one-hot select, bit addr_i+1 set
// ---------------------------------------------------------------------------
module addr_decoder_5to32 (
  input  logic [4:0]  addr_i,
  output logic [32:1] onehot_o
);

  for (genvar gi = 0; gi < 32; gi++) begin : g_bit
    assign onehot_o[gi+1] = (addr_i == 5'(gi));
  end

endmodule

// File: rtl/regfile_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_arbiter
// Register file of NUM_REG x WIDTH entries shared by two requesters (A, B)
// through a round-robin arbiter, with a background clear engine that zeroes
// one entry per cycle.
//
// Optional feature (compile-time macro REGFILE_ARBITER_ZERO_REG_EN):
//   defined   -> entry 1 (address 0) is hard-wired to zero: writes are
//                dropped and reads return 0.
//   undefined -> entry 1 is an ordinary register.
//
// Parameters
//   NUM_REG  number of entries (1..32), addressed 0..NUM_REG-1
//   WIDTH    data width in bits
//
// Ports
//   clk                 single clock, rising edge
//   reset               asynchronous, active-high
//   ReqA/ReqB           access request per requester
//   WeA/WeB             1 = write, 0 = read
//   AddrA/AddrB [4:0]   zero-based entry address
//   WdataA/WdataB       write data
//   GntA/GntB           combinational grant (same cycle as the request)
//   RvalidA/RvalidB     read data valid, one cycle after a read grant
//   Rdata               shared read data, 0 when no read result is presented
//   ClearStart          pulse: start a full-file clear
//   Busy                high while the clear runs (grants are blocked)
//   ClearDone           one-cycle pulse on the return to IDLE
// ---------------------------------------------------------------------------
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REG = NUM_REG_DEFAULT,
  parameter int WIDTH   = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ReqA,
  input  logic             ReqB,
  input  logic             WeA,
  input  logic             WeB,
  input  logic [4:0]       AddrA,
  input  logic [4:0]       AddrB,
  input  logic [WIDTH-1:0] WdataA,
  input  logic [WIDTH-1:0] WdataB,
  output logic             GntA,
  output logic             GntB,
  output logic             RvalidA,
  output logic             RvalidB,
  output logic [WIDTH-1:0] Rdata,
  input  logic             ClearStart,
  output logic             Busy,
  output logic             ClearDone
);

`ifdef REGFILE_ARBITER_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  // Counter value of the final clear cycle (entry NUM_REG).
  localparam logic [4:0] LAST_IDX = 5'(NUM_REG - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [0:0]       state_q, state_d;
  req_id_t          ptr_q, ptr_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             rvalid_a_q, rvalid_a_d;
  logic             rvalid_b_q, rvalid_b_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             clear_done_q, clear_done_d;
  logic [WIDTH-1:0] mem_q [1:NUM_REG];

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic             in_idle;
  logic             in_clear;
  logic             gnt_a;
  logic             gnt_b;
  logic             gnt_any;
  logic             acc_we;
  logic [4:0]       acc_addr;
  logic [WIDTH-1:0] acc_wdata;

  assign in_idle  = (state_q == ST_IDLE);
  assign in_clear = ~in_idle;

  // Grants are also forced low while reset is held, so the outputs are quiet
  // during reset even if a requester is already asserting Req.
  assign gnt_a = in_idle & ~reset & ReqA & (~ReqB | (ptr_q == REQ_A));
  assign gnt_b = in_idle & ~reset & ReqB & (~ReqA | (ptr_q == REQ_B));
  assign gnt_any = gnt_a | gnt_b;

  // Winner's request fields; only meaningful when gnt_any is high.
  assign acc_we    = gnt_a ? WeA    : WeB;
  assign acc_addr  = gnt_a ? AddrA  : AddrB;
  assign acc_wdata = gnt_a ? WdataA : WdataB;

  // -------------------------------------------------------------------------
  // Address decode: a single decoder serves both the clear engine and the
  // requesters, since the two never use the file in the same cycle.
  // -------------------------------------------------------------------------
  logic [4:0]  dec_addr;
  logic [32:1] dec_onehot;

  assign dec_addr = in_clear ? cnt_q : acc_addr;

  addr_decoder_5to32 u_addr_dec (
    .addr_i   (dec_addr),
    .onehot_o (dec_onehot)
  );

  // -------------------------------------------------------------------------
  // Storage. Each entry is its own register so that reset can zero the whole
  // file at once. A selected entry is either zeroed (clear engine) or loaded
  // with the granted write data. Addresses at or above NUM_REG select no
  // entry, which turns such writes into no-ops.
  // -------------------------------------------------------------------------
  logic             file_we;
  logic [WIDTH-1:0] file_wdata;

  assign file_we    = in_clear | (gnt_any & acc_we);
  assign file_wdata = in_clear ? '0 : acc_wdata;

  for (genvar gi = 1; gi <= NUM_REG; gi++) begin : g_entry
    // Entry 1 never loads when it is hard-wired to zero.
    localparam bit WRITABLE = !(ZERO_REG && (gi == 1));
    logic entry_we;

    assign entry_we = WRITABLE & file_we & dec_onehot[gi];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        mem_q[gi] <= '0;
      end else if (entry_we) begin
        mem_q[gi] <= file_wdata;
      end
    end
  end

  // Read mux: AND-OR over the one-hot select; an out-of-range address
  // selects nothing and reads 0.
  logic [WIDTH-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    for (int e = 1; e <= NUM_REG; e++) begin
      if (dec_onehot[e] && !(ZERO_REG && (e == 1))) begin
        rd_word = rd_word | mem_q[e];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clear_done_d = 1'b0;
    if (in_idle) begin
      // A request granted in this same cycle is still served on this edge.
      if (ClearStart) begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    end else begin
      // ClearStart is deliberately not looked at here.
      if (cnt_q == LAST_IDX) begin
        state_d      = ST_IDLE;
        cnt_d        = '0;
        clear_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_a) begin
      ptr_d = other_req(REQ_A);
    end else if (gnt_b) begin
      ptr_d = other_req(REQ_B);
    end
  end

  // Read results are captured at the end of the grant cycle. A write to the
  // same entry in the preceding cycle has already landed by then, so no
  // bypass path is needed. Rdata idles at 0 whenever no read is presented.
  always_comb begin
    rvalid_a_d = gnt_a & ~WeA;
    rvalid_b_d = gnt_b & ~WeB;
    rdata_d    = (gnt_any & ~acc_we) ? rd_word : '0;
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= REQ_A;
      cnt_q        <= '0;
      rvalid_a_q   <= 1'b0;
      rvalid_b_q   <= 1'b0;
      rdata_q      <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      rvalid_a_q   <= rvalid_a_d;
      rvalid_b_q   <= rvalid_b_d;
      rdata_q      <= rdata_d;
      clear_done_q <= clear_done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign GntA      = gnt_a;
  assign GntB      = gnt_b;
  assign RvalidA   = rvalid_a_q;
  assign RvalidB   = rvalid_b_q;
  assign Rdata     = rdata_q;
  assign Busy      = in_clear;
  assign ClearDone = clear_done_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_arbiter
// Self-checking bench for regfile_arbiter: a vector table for the basic
// read/write/arbitration cases, hand-written sequences for clear and reset
// corner cases, and a randomized run against a behavioural model.
// ---------------------------------------------------------------------------
module tb_regfile_arbiter;

  localparam int NREG = 32;
  localparam int W    = 16;

`ifdef REGFILE_ARBITER_ZERO_REG_EN
  localparam bit          ZERO_EN   = 1'b1;
  localparam logic [15:0] ADDR0_EXP = 16'h0000;
`else
  localparam bit          ZERO_EN   = 1'b0;
  localparam logic [15:0] ADDR0_EXP = 16'hFFFF;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         ReqA, ReqB, WeA, WeB;
  logic [4:0]   AddrA, AddrB;
  logic [W-1:0] WdataA, WdataB;
  logic         GntA, GntB, RvalidA, RvalidB;
  logic [W-1:0] Rdata;
  logic         ClearStart;
  logic         Busy, ClearDone;

  always #5 clk = ~clk;

  regfile_arbiter #(.NUM_REG(NREG), .WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .ReqA       (ReqA),
    .ReqB       (ReqB),
    .WeA        (WeA),
    .WeB        (WeB),
    .AddrA      (AddrA),
    .AddrB      (AddrB),
    .WdataA     (WdataA),
    .WdataB     (WdataB),
    .GntA       (GntA),
    .GntB       (GntB),
    .RvalidA    (RvalidA),
    .RvalidB    (RvalidB),
    .Rdata      (Rdata),
    .ClearStart (ClearStart),
    .Busy       (Busy),
    .ClearDone  (ClearDone)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One vector = inputs for one cycle, grants expected in that cycle, and
  // read outputs expected after the closing edge.
  typedef struct {
    logic        req_a, we_a;
    logic [4:0]  addr_a;
    logic [15:0] wdata_a;
    logic        req_b, we_b;
    logic [4:0]  addr_b;
    logic [15:0] wdata_b;
    logic        exp_gnt_a, exp_gnt_b, exp_rv_a, exp_rv_b;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [13];

  task automatic idle_inputs();
    ReqA = 1'b0; ReqB = 1'b0; WeA = 1'b0; WeB = 1'b0;
    AddrA = '0; AddrB = '0; WdataA = '0; WdataB = '0;
    ClearStart = 1'b0;
  endtask

  task automatic go_idle();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Lone access by one requester; checks the immediate grant and, for reads,
  // the data returned one cycle later.
  task automatic single(input logic use_b, input logic we, input logic [4:0] addr,
                        input logic [15:0] data, input logic [15:0] exp_rd, input string tag);
    @(negedge clk);
    ClearStart = 1'b0;
    ReqA = ~use_b; WeA = we; AddrA = addr; WdataA = data;
    ReqB = use_b;  WeB = we; AddrB = addr; WdataB = data;
    #1;
    check({tag, "_gnt"}, use_b ? GntB : GntA, 1'b1);
    @(posedge clk);
    #1;
    if (!we) begin
      check({tag, "_rvalid"}, use_b ? RvalidB : RvalidA, 1'b1);
      check({tag, "_rdata"}, Rdata, exp_rd);
    end
    $display("txn %s req=%s we=%0d addr=%0d wdata=%h rdata=%h", tag, use_b ? "B" : "A", we, addr, data, Rdata);
  endtask

  // Behavioural model state for the random run.
  logic [15:0] mm [0:31];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();

    // ---------------- reset state (a request is held during reset) --------
    ReqA = 1'b1; ReqB = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_gnt_a", GntA, 1'b0);
    check("rst_gnt_b", GntB, 1'b0);
    check("rst_rvalid_a", RvalidA, 1'b0);
    check("rst_rvalid_b", RvalidB, 1'b0);
    check("rst_rdata", Rdata, 16'h0);
    check("rst_busy", Busy, 1'b0);
    check("rst_cleardone", ClearDone, 1'b0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;

    // ---------------- vector table -----------------------------------------
    //           rA    wA    aA     dA        rB    wB    aB     dB         gA    gB    vA    vB    rdata
    vecs[0]  = '{1'b1, 1'b0, 5'd0, 16'h0000, 1'b1, 1'b0, 5'd1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 5'd0, 16'h0000, 1'b1, 1'b0, 5'd1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 5'd0, 16'h0000, 1'b1, 1'b0, 5'd1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[3]  = '{1'b1, 1'b0, 5'd0, 16'h0000, 1'b1, 1'b0, 5'd1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000};
    vecs[4]  = '{1'b1, 1'b1, 5'd3, 16'hBEEF, 1'b0, 1'b0, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[5]  = '{1'b1, 1'b0, 5'd3, 16'h0000, 1'b0, 1'b0, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF};
    vecs[6]  = '{1'b0, 1'b0, 5'd0, 16'h0000, 1'b1, 1'b1, 5'd7, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[7]  = '{1'b1, 1'b0, 5'd7, 16'h0000, 1'b0, 1'b0, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234};
    vecs[8]  = '{1'b1, 1'b1, 5'd0, 16'hFFFF, 1'b0, 1'b0, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[9]  = '{1'b0, 1'b0, 5'd0, 16'h0000, 1'b1, 1'b0, 5'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, ADDR0_EXP};
    vecs[10] = '{1'b0, 1'b0, 5'd0, 16'h0000, 1'b0, 1'b0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[11] = '{1'b1, 1'b1, 5'd5, 16'hAAAA, 1'b1, 1'b0, 5'd5, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[12] = '{1'b0, 1'b0, 5'd0, 16'h0000, 1'b1, 1'b0, 5'd5, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'hAAAA};

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      ReqA = vecs[i].req_a; WeA = vecs[i].we_a; AddrA = vecs[i].addr_a; WdataA = vecs[i].wdata_a;
      ReqB = vecs[i].req_b; WeB = vecs[i].we_b; AddrB = vecs[i].addr_b; WdataB = vecs[i].wdata_b;
      ClearStart = 1'b0;
      #1;
      check($sformatf("vec%0d_gnt_a", i), GntA, vecs[i].exp_gnt_a);
      check($sformatf("vec%0d_gnt_b", i), GntB, vecs[i].exp_gnt_b);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_rvalid_a", i), RvalidA, vecs[i].exp_rv_a);
      check($sformatf("vec%0d_rvalid_b", i), RvalidB, vecs[i].exp_rv_b);
      check($sformatf("vec%0d_rdata", i), Rdata, vecs[i].exp_rdata);
      $display("txn vec%0d gntA=%0d gntB=%0d rvA=%0d rvB=%0d rdata=%h", i, vecs[i].exp_gnt_a,
               vecs[i].exp_gnt_b, RvalidA, RvalidB, Rdata);
    end
    go_idle();

    // ---------------- full clear, with a stray ClearStart mid-clear --------
    for (int i = 0; i < NREG; i++) single(1'b0, 1'b1, 5'(i), 16'h1000 + 16'(i), 16'h0, $sformatf("fill%0d", i));
    @(negedge clk);
    idle_inputs();
    ClearStart = 1'b1;
    @(posedge clk);
    #1;
    check("clr_busy_start", Busy, 1'b1);
    for (int k = 1; k <= NREG; k++) begin
      @(negedge clk);
      ClearStart = (k == 5);
      ReqA = 1'b1; WeA = 1'b1; AddrA = 5'(k - 1); WdataA = 16'hDEAD;
      ReqB = 1'b1; WeB = 1'b0; AddrB = 5'(k - 1);
      #1;
      check($sformatf("clr%0d_gnt_a", k), GntA, 1'b0);
      check($sformatf("clr%0d_gnt_b", k), GntB, 1'b0);
      @(posedge clk);
      #1;
      check($sformatf("clr%0d_busy", k), Busy, (k < NREG));
      check($sformatf("clr%0d_done", k), ClearDone, (k == NREG));
    end
    $display("txn clear complete");
    go_idle();
    @(posedge clk);
    #1;
    check("clr_done_pulse_end", ClearDone, 1'b0);
    for (int i = 0; i < NREG; i++) single(1'b1, 1'b0, 5'(i), 16'h0, 16'h0, $sformatf("postclr%0d", i));

    // ---------------- reset during a pending read ---------------------------
    single(1'b0, 1'b1, 5'd2, 16'h5A5A, 16'h0, "mr_wr");
    single(1'b0, 1'b0, 5'd2, 16'h0, 16'h5A5A, "mr_rd");
    #2;
    reset = 1'b1;
    #1;
    check("mr_rvalid_dropped", RvalidA, 1'b0);
    check("mr_rdata_zero", Rdata, 16'h0);
    check("mr_gnt_in_reset", GntA, 1'b0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    single(1'b0, 1'b0, 5'd2, 16'h0, 16'h0, "mr_after");

    // ---------------- reset at clear cycle 10 -------------------------------
    for (int i = 0; i < NREG; i++) single(1'b0, 1'b1, 5'(i), 16'hC000 + 16'(i), 16'h0, $sformatf("refill%0d", i));
    @(negedge clk);
    idle_inputs();
    ClearStart = 1'b1;
    @(posedge clk);
    #1;
    check("rc_busy_start", Busy, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      ClearStart = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rc_busy_dropped", Busy, 1'b0);
    check("rc_cleardone", ClearDone, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    single(1'b0, 1'b0, 5'd20, 16'h0, 16'h0, "rc_idle_grant");
    for (int i = 0; i < NREG; i++) single(1'b1, 1'b0, 5'(i), 16'h0, 16'h0, $sformatf("rc_rd%0d", i));

    // ---------------- randomized run against the model ----------------------
    do_reset();
    begin
      bit          pa, pb, favour_b, cs, eg_a, eg_b, erv_a, erv_b, ecd;
      logic        wa, wb;
      logic [4:0]  aa, ab;
      logic [15:0] da, db, erd;
      int          busy_left;
      pa = 0; pb = 0; favour_b = 0; busy_left = 0;
      wa = 0; wb = 0; aa = 0; ab = 0; da = 0; db = 0;
      for (int i = 0; i < 32; i++) mm[i] = 16'h0;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        if (!pa && $urandom_range(0, 1) == 1) begin
          pa = 1; wa = 1'($urandom_range(0, 1)); aa = 5'($urandom_range(0, 31)); da = 16'($urandom);
        end
        if (!pb && $urandom_range(0, 1) == 1) begin
          pb = 1; wb = 1'($urandom_range(0, 1)); ab = 5'($urandom_range(0, 31)); db = 16'($urandom);
        end
        cs = ($urandom_range(0, 39) == 0);
        ReqA = pa; WeA = wa; AddrA = aa; WdataA = da;
        ReqB = pb; WeB = wb; AddrB = ab; WdataB = db;
        ClearStart = cs;

        eg_a = (busy_left == 0) && pa && (!pb || !favour_b);
        eg_b = (busy_left == 0) && pb && (!pa || favour_b);
        #1;
        check($sformatf("rnd%0d_gnt_a", c), GntA, eg_a);
        check($sformatf("rnd%0d_gnt_b", c), GntB, eg_b);

        erv_a = 0; erv_b = 0; erd = 16'h0;
        if (eg_a) begin
          if (wa) begin
            if (!(ZERO_EN && aa == 0)) mm[aa] = da;
          end else begin
            erv_a = 1; erd = (ZERO_EN && aa == 0) ? 16'h0 : mm[aa];
          end
          pa = 0; favour_b = 1;
        end else if (eg_b) begin
          if (wb) begin
            if (!(ZERO_EN && ab == 0)) mm[ab] = db;
          end else begin
            erv_b = 1; erd = (ZERO_EN && ab == 0) ? 16'h0 : mm[ab];
          end
          pb = 0; favour_b = 0;
        end

        ecd = 0;
        if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) ecd = 1;
        end else if (cs) begin
          busy_left = NREG;
          for (int i = 0; i < 32; i++) mm[i] = 16'h0;
        end

        @(posedge clk);
        #1;
        check($sformatf("rnd%0d_rvalid_a", c), RvalidA, erv_a);
        check($sformatf("rnd%0d_rvalid_b", c), RvalidB, erv_b);
        check($sformatf("rnd%0d_rdata", c), Rdata, erd);
        check($sformatf("rnd%0d_busy", c), Busy, (busy_left > 0));
        check($sformatf("rnd%0d_cleardone", c), ClearDone, ecd);
        if (eg_a || eg_b)
          $display("txn rnd%0d gnt=%s we=%0d addr=%0d rdata=%h", c, eg_a ? "A" : "B",
                   eg_a ? wa : wb, eg_a ? aa : ab, Rdata);
      end
    end
    go_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 SHALL take parameter NUM_REG, default 32, the number of register entries (indices 1..NUM_REG).
REQ-002 SHALL take parameter WIDTH, default 16, the data width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have ports ReqA/ReqB, input, 1, requester A/B access request.
REQ-006 SHALL have ports WeA/WeB, input, 1, write (1) or read (0) for requester A/B.
REQ-007 SHALL have ports AddrA/AddrB, input, 5, zero-based entry address; 0 selects entry 1.
REQ-008 SHALL have ports WdataA/WdataB, input, WIDTH, write data for requester A/B.
REQ-009 SHALL have ports GntA/GntB, output, 1, combinational grant for requester A/B.
REQ-010 SHALL have ports RvalidA/RvalidB, output, 1, read data valid for requester A/B.
REQ-011 SHALL have port Rdata, output, WIDTH, read data shared by both requesters.
REQ-012 SHALL have port ClearStart, input, 1, pulse that starts a full-file clear.
REQ-013 SHALL have port Busy, output, 1, high while a clear is in progress.
REQ-014 SHALL have port ClearDone, output, 1, one-cycle pulse when a clear completes.

Function
REQ-015 SHALL hold NUM_REG x WIDTH storage, with each address decoded one-hot before it selects an entry.
REQ-016 SHALL use FSM states IDLE and CLEAR: IDLE->CLEAR on ClearStart, CLEAR->IDLE after the last entry is cleared.
REQ-017 In IDLE, SHALL grant at most one requester per cycle; a lone requester is granted immediately.
REQ-018 On simultaneous ReqA and ReqB, SHALL grant the requester named by a round-robin pointer.
REQ-019 SHALL move the pointer to the non-granted requester after every grant; the pointer is unchanged when no grant occurs.
REQ-020 SHALL perform a granted write at the rising edge ending the grant cycle.
REQ-021 SHALL present granted-read data on Rdata with RvalidX high exactly one cycle after the grant; otherwise Rdata is 0.
REQ-022 For a read of the entry written in the previous cycle, SHALL return the new value.
REQ-023 A requester SHALL hold Req, We, Addr and Wdata stable until it sees its grant; the block samples these only in the grant cycle.
REQ-024 In CLEAR, SHALL hold GntA/GntB low and Busy high.
REQ-025 In CLEAR, SHALL zero one entry per cycle, ascending from 1, using a 5-bit counter; the clear takes NUM_REG cycles.
REQ-026 SHALL pulse ClearDone in the cycle the FSM returns to IDLE.
REQ-027 SHALL ignore ClearStart while in CLEAR.
REQ-028 On ClearStart together with a request in IDLE, SHALL serve the request that cycle and enter CLEAR on the same edge.
REQ-029 SHALL treat addresses >= NUM_REG as no-ops: writes are discarded and reads return 0 with RvalidX still asserted.

Reset
REQ-030 On reset, SHALL set FSM=IDLE, pointer=A, counter=0, storage all zero, and GntA=GntB=RvalidA=RvalidB=Busy=ClearDone=0 and Rdata=0.
REQ-031 On reset asserted mid-clear or mid-read, SHALL abort the operation and drop any pending Rvalid.

Configuration
REQ-032 With macro REGFILE_ARBITER_ZERO_REG_EN defined, SHALL discard writes to entry 1 and always read entry 1 as 0.
REQ-033 Without REGFILE_ARBITER_ZERO_REG_EN, SHALL treat entry 1 as a normal register.

Structure
REQ-034 SHALL place NUM_REG and WIDTH defaults, the FSM state encoding and the requester-ID type in shared package regfile_pkg.
REQ-035 SHALL instantiate one sub-module, addr_decoder_5to32, a combinational 5-bit to 32-bit one-hot decoder with bit i+1 set for address i.

Verification
REQ-036 The bench SHALL check: A writes 16'hBEEF to addr 3, then A reads addr 3 -> RvalidA one cycle after the grant with Rdata=16'hBEEF.
REQ-037 The bench SHALL check: ReqA and ReqB held high for 4 cycles after reset -> grants alternate A,B,A,B.
REQ-038 The bench SHALL check: B writes 16'h1234 to addr 7 and A reads addr 7 the next cycle -> Rdata=16'h1234.
REQ-039 The bench SHALL check: after filling all entries, ClearStart -> Busy high for 32 cycles, no grants, ClearDone pulse, then all reads return 0.
REQ-040 The bench SHALL check: reset asserted at clear cycle 10 -> Busy=0 immediately, FSM=IDLE, all entries 0.
REQ-041 The bench SHALL check: a write of 16'hFFFF to addr 0 followed by a read -> 0 with REGFILE_ARBITER_ZERO_REG_EN defined, 16'hFFFF without it.
